serout_merge: RTL and testbench

Parametrised merger of several single-bit serial sources (tape out, MIDI out, UART TX, future channels) onto one shared UART_TX pin, in the clk_sys domain of the top level. Replaces edge-following, last-writer-wins muxing with an ownership arbiter. The first active channel owns the pin until it has been idle for a programmable hold time. Edges from other channels during ownership are blocked and flagged. Per-channel enables allow the OSD to disable sources.

---
 rtl/serout_merge.sv | 157 +++++++++++++++
 tb/tb_serout_merge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serout_merge.sv
// Ownership arbiter merging CHANNELS serial sources onto one line; lowest-index edge claims, owner keeps the line until idle for HOLD_CYCLES.
// Latency din->dout 1 cycle, or 3 cycles with SEROUT_MERGE_SYNC_EN defined (2-FF input synchronisers).
// No backpressure: non-owner edges while owned are dropped and reported on the collision pulse.
module serout_merge #(
    parameter int   CHANNELS    = 3,
    parameter int   HOLD_CYCLES = 84000,
    parameter logic IDLE_LEVEL  = 1'b1,
    parameter int   IDW         = $clog2(CHANNELS)
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] din,
    input  logic [CHANNELS-1:0] chan_en,
    output logic                dout,
    output logic                owner_valid,
    output logic [IDW-1:0]      owner_id,
    output logic                collision
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]       HOLD_RELOAD = HW'(HOLD_CYCLES);
    localparam logic [CHANNELS-1:0] IDLE_VEC    = {CHANNELS{IDLE_LEVEL}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // Assert asynchronously, deassert after two clk_sys edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [CHANNELS-1:0] din_s;

`ifdef SEROUT_MERGE_SYNC_EN
    logic [CHANNELS-1:0] din_meta_q;
    logic [CHANNELS-1:0] din_sync_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            din_meta_q <= IDLE_VEC;
            din_sync_q <= IDLE_VEC;
        end else begin
            din_meta_q <= din;
            din_sync_q <= din_meta_q;
        end
    end

    assign din_s = din_sync_q;
`else
    assign din_s = din;
`endif

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] din_prev_q;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                dout_q, dout_d;
    logic                coll_q, coll_d;

    logic [CHANNELS-1:0] edg;
    logic [IDW-1:0]      win_id;
    logic [CHANNELS-1:0] win_mask;
    logic [CHANNELS-1:0] own_mask;

    assign edg      = (din_s ^ din_prev_q) & chan_en;
    assign win_mask = CHANNELS'(1) << win_id;
    assign own_mask = CHANNELS'(1) << owner_q;

    always_comb begin
        win_id = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (edg[i]) begin
                win_id = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            din_prev_q <= IDLE_VEC;
            owner_q    <= '0;
            hold_q     <= '0;
            dout_q     <= IDLE_LEVEL;
            coll_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            din_prev_q <= din_s;
            owner_q    <= owner_d;
            hold_q     <= hold_d;
            dout_q     <= dout_d;
            coll_q     <= coll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        dout_d  = IDLE_LEVEL;
        coll_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|edg) begin
                    state_d = ST_OWNED;
                    owner_d = win_id;
                    dout_d  = din_s[win_id];
                    hold_d  = HOLD_RELOAD;
                    coll_d  = |(edg & ~win_mask);
                end
            end
            ST_OWNED: begin
                dout_d = din_s[owner_q];
                coll_d = |(edg & ~own_mask);
                if (!chan_en[owner_q]) begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                    hold_d  = '0;
                    dout_d  = IDLE_LEVEL;
                end else if (edg[owner_q]) begin
                    hold_d = HOLD_RELOAD;
                end else if (din_s[owner_q] == IDLE_LEVEL) begin
                    // The last idle cycle of the hold window releases rather than parking at zero.
                    if (hold_q <= HW'(1)) begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                        hold_d  = '0;
                        dout_d  = IDLE_LEVEL;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dout        = dout_q;
    assign owner_valid = (state_q == ST_OWNED);
    assign owner_id    = owner_q;
    assign collision   = coll_q;

endmodule

// File: tb/tb_serout_merge.sv
// Directed and random stimulus for serout_merge checked against a timestamp-based ownership model.
module tb_serout_merge;

    localparam int   CH   = 3;
    localparam int   HOLD = 8;
    localparam logic IDL  = 1'b1;
`ifdef SEROUT_MERGE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] din     = 3'b010;
    logic [CH-1:0] chan_en = 3'b111;
    logic          dout;
    logic          owner_valid;
    logic [1:0]    owner_id;
    logic          collision;

    always #5 clk_sys = ~clk_sys;

    serout_merge #(
        .CHANNELS   (CH),
        .HOLD_CYCLES(HOLD),
        .IDLE_LEVEL (IDL)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .din        (din),
        .chan_en    (chan_en),
        .dout       (dout),
        .owner_valid(owner_valid),
        .owner_id   (owner_id),
        .collision  (collision)
    );

    int ncmp  = 0;
    int nfail = 0;

    // Model: owner index (-1 = free), edge number of last owner activity.
    int            m_owner;
    int            m_last;
    int            m_n;
    logic [CH-1:0] m_prev;
    logic          m_dout;
    logic          m_coll;
    logic [CH-1:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [CH-1:0] v);
        for (int i = 0; i < CH; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_n     = 0;
        m_prev  = '1;
        m_dout  = IDL;
        m_coll  = 1'b0;
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back('1);
    endtask

    task automatic model_edge();
        logic [CH-1:0] eff;
        logic [CH-1:0] edges;
        int            w;
        m_n++;
        hist.push_back(din);
        eff = hist[hist.size() - 1 - SYNC];
        if (hist.size() > 8) void'(hist.pop_front());
        edges = (eff ^ m_prev) & chan_en;
        if (m_owner < 0) begin
            w      = lowest(edges);
            m_coll = 1'b0;
            m_dout = IDL;
            if (w >= 0) begin
                m_owner = w;
                m_last  = m_n;
                m_dout  = eff[w];
                m_coll  = (edges & ~(CH'(1) << w)) != '0;
            end
        end else begin
            m_coll = (edges & ~(CH'(1) << m_owner)) != '0;
            if (!chan_en[m_owner]) begin
                m_owner = -1;
                m_dout  = IDL;
            end else if (edges[m_owner] || eff[m_owner] != IDL) begin
                m_last = m_n;
                m_dout = eff[m_owner];
            end else if (m_n - m_last >= HOLD) begin
                m_owner = -1;
                m_dout  = IDL;
            end else begin
                m_dout = eff[m_owner];
            end
        end
        m_prev = eff;
    endtask

    task automatic step(input string tag);
        @(posedge clk_sys);
        model_edge();
        #1;
        chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
        chk({tag, ".valid"}, 32'(owner_valid), 32'(m_owner >= 0));
        chk({tag, ".id"}, 32'(owner_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk({tag, ".coll"}, 32'(collision), 32'(m_coll));
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".dout"}, 32'(dout), 32'(IDL));
        chk({tag, ".valid"}, 32'(owner_valid), 32'd0);
        chk({tag, ".id"}, 32'(owner_id), 32'd0);
        chk({tag, ".coll"}, 32'(collision), 32'd0);
    endtask

    initial begin
        int lat;
        int ncoll;

        // Reset held with a non-idle input.
        repeat (3) @(posedge clk_sys);
        #1;
        chk_idle_outputs("reset");

        // Release with all lines idle: nothing may claim.
        din     = 3'b111;
        reset_n = 1'b1;
        model_reset();
        steps("post_reset", 6);
        chk_idle_outputs("no_claim");

        // Single claim on channel 1, then measure release latency.
        din[1] = 1'b0;
        steps("claim", 1 + SYNC);
        chk("claim_valid", 32'(owner_valid), 32'd1);
        chk("claim_id", 32'(owner_id), 32'd1);
        chk("claim_dout", 32'(dout), 32'd0);
        steps("claim_hold", 8);
        din[1] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            step("release");
            if (!owner_valid) begin
                lat = k;
                break;
            end
        end
        chk("release_latency", 32'(lat), 32'(HOLD + 1 + SYNC));

        // Simultaneous toggle on channels 0 and 2.
        steps("gap", 3);
        din   = 3'b010;
        ncoll = 0;
        for (int k = 0; k < 6; k++) begin
            step("simul");
            if (collision) ncoll++;
        end
        chk("simul_id", 32'(owner_id), 32'd0);
        chk("simul_coll_count", 32'(ncoll), 32'd1);
        din[0] = 1'b1;
        steps("simul_follow", 2 + SYNC);
        chk("simul_dout", 32'(dout), 32'd1);
        din = 3'b111;
        steps("simul_idle", HOLD + SYNC + 4);
        chk("simul_released", 32'(owner_valid), 32'd0);

        // Channel 2 owns; channel 0 toggles three times and is blocked.
        din[2] = 1'b0;
        steps("own2", 2);
        din[2] = 1'b1;
        step("own2_idle");
        ncoll = 0;
        din[0] = 1'b0;
        step("blk");
        if (collision) ncoll++;
        din[0] = 1'b1;
        step("blk");
        if (collision) ncoll++;
        din[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("blk");
            if (collision) ncoll++;
        end
        chk("blk_coll_count", 32'(ncoll), 32'd3);
        chk("blk_owner", 32'(owner_id), 32'd2);
        for (int k = 0; k < 20; k++) begin
            if (!owner_valid) break;
            step("blk_timeout");
        end
        chk("blk_released", 32'(owner_valid), 32'd0);
        din[0] = 1'b1;
        steps("reclaim", 1 + SYNC);
        chk("reclaim_valid", 32'(owner_valid), 32'd1);
        chk("reclaim_id", 32'(owner_id), 32'd0);
        steps("reclaim_idle", HOLD + SYNC + 3);

        // Stuck-low owner, then disable it.
        din[1] = 1'b0;
        steps("stuck", 100);
        chk("stuck_valid", 32'(owner_valid), 32'd1);
        chk("stuck_dout", 32'(dout), 32'd0);
        chan_en[1] = 1'b0;
        step("disable");
        chk("disable_valid", 32'(owner_valid), 32'd0);
        chk("disable_dout", 32'(dout), 32'd1);
        din[1] = 1'b1;
        steps("disable_idle", 3);
        chan_en = 3'b111;
        steps("enable_idle", 3);

        // Mid-frame asynchronous reset.
        din[2] = 1'b0;
        steps("pre_rst", 2 + SYNC);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("midframe_rst");
        din = 3'b111;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        model_reset();
        steps("post_rst2", 5);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(5) == 0) din[$urandom_range(CH - 1)] ^= 1'b1;
            if ($urandom_range(149) == 0) chan_en[$urandom_range(CH - 1)] ^= 1'b1;
            if ($urandom_range(39) == 0) din = 3'b111;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
